// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op codes, FSM states and flag indices
// shared by the serial ALU and its bench.
package serial_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_ADC = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_MOV = 4'd7,
    OP_CMP = 4'd8,
    OP_NEG = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 3;

  function automatic logic is_arith(op_e o);
    return !(o inside {OP_AND, OP_OR, OP_XOR, OP_MOV});
  endfunction

endpackage

// File: rtl/serial_alu_n_if.sv
// serial_alu_n_if: command, digit stream and flag bundle
// between a host (master) and the serial ALU (slave).
interface serial_alu_n_if #(
  parameter int DIGIT_BITS = 2,
  parameter int MAX_WORDS  = 4
);
  localparam int LW = $clog2(MAX_WORDS) + 1;

  logic                  start;
  logic [3:0]            op;
  logic [LW-1:0]         len_words;
  logic                  update_flags;
  logic                  in_valid;
  logic [DIGIT_BITS-1:0] a_in;
  logic [DIGIT_BITS-1:0] b_in;
  logic                  in_ready;
  logic                  out_valid;
  logic [DIGIT_BITS-1:0] result_out;
  logic                  busy;
  logic                  done;
  logic                  flag_c;
  logic                  flag_v;
  logic                  flag_s;
  logic                  flag_z;

  modport master (
    output start, op, len_words, update_flags,
    output in_valid, a_in, b_in,
    input  in_ready, out_valid, result_out,
    input  busy, done,
    input  flag_c, flag_v, flag_s, flag_z
  );

  modport slave (
    input  start, op, len_words, update_flags,
    input  in_valid, a_in, b_in,
    output in_ready, out_valid, result_out,
    output busy, done,
    output flag_c, flag_v, flag_s, flag_z
  );

endinterface

// File: rtl/serial_adder_digit.sv
// serial_adder_digit: one digit of a ripple add with
// carry-out and signed overflow of that digit.
module serial_adder_digit #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  logic [W:0] s;

  assign s    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  assign sum  = s[W-1:0];
  assign cout = s[W];
  assign ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);

endmodule

// File: rtl/serial_alu_n.sv
// serial_alu_n: digit-serial multi-word ALU, LSB digit first,
// carry chained across digits, C/V/S/Z flags at op end.
module serial_alu_n
  import serial_alu_pkg::*;
#(
  parameter int DIGIT_BITS = 2,
  parameter int REG_BITS   = 8,
  parameter int MAX_WORDS  = 4
) (
  input logic           clk,
  input logic           reset,
  serial_alu_n_if.slave bus
);
  localparam int DPW  = REG_BITS / DIGIT_BITS;
  localparam int NMAX = MAX_WORDS * DPW;
  localparam int CW   = $clog2(NMAX) + 1;
  localparam int LW   = $clog2(MAX_WORDS) + 1;
  localparam int MSB  = DIGIT_BITS - 1;

  typedef logic [DIGIT_BITS-1:0] dig_t;

  state_e        state;
  op_e           op_q;
  logic          upd_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] last_c;
  logic [LW-1:0] len_c;
  logic          carry;
  logic          v_pend;
  logic          s_pend;
  logic          z_acc;
  logic [3:0]    flags;
  logic          out_v;
  dig_t          res_q;

  logic xfer, first, cin0, cin, cout, ovf;
  dig_t x, y, sum, res;

  assign xfer  = (state == ST_RUN) && bus.in_valid;
  assign first = (cnt == '0);
  assign cin   = first ? cin0 : carry;

  always_comb begin
    len_c = bus.len_words;
    if (len_c == '0)
      len_c = LW'(1);
    else if (len_c > LW'(MAX_WORDS))
      len_c = LW'(MAX_WORDS);
  end

  assign last_c = CW'(len_c) * CW'(DPW) - CW'(1);

  // SBC chains the stored carry like ADC; C=1 means no borrow
  always_comb begin
    x    = bus.a_in;
    y    = bus.b_in;
    cin0 = 1'b0;
    unique case (op_q)
      OP_SUB, OP_CMP: begin
        y    = ~bus.b_in;
        cin0 = 1'b1;
      end
      OP_SBC: begin
        y    = ~bus.b_in;
        cin0 = flags[FLAG_C];
      end
      OP_ADC: cin0 = flags[FLAG_C];
      OP_NEG: begin
        x    = '0;
        y    = ~bus.a_in;
        cin0 = 1'b1;
      end
      default: ;
    endcase
  end

  serial_adder_digit #(.W(DIGIT_BITS)) u_add (
    .x    (x),
    .y    (y),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always_comb begin
    res = sum;
    unique case (op_q)
      OP_AND:  res = bus.a_in & bus.b_in;
      OP_OR:   res = bus.a_in | bus.b_in;
      OP_XOR:  res = bus.a_in ^ bus.b_in;
      OP_MOV:  res = bus.b_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      upd_q  <= 1'b0;
      cnt    <= '0;
      last   <= '0;
      carry  <= 1'b0;
      v_pend <= 1'b0;
      s_pend <= 1'b0;
      z_acc  <= 1'b0;
      flags  <= '0;
      out_v  <= 1'b0;
      res_q  <= '0;
    end else begin
      out_v <= xfer && (op_q != OP_CMP);
      if (xfer) begin
        res_q  <= res;
        cnt    <= cnt + CW'(1);
        carry  <= cout;
        v_pend <= ovf;
        s_pend <= res[MSB];
        z_acc  <= (first | z_acc) & (res == '0);
      end
      unique case (state)
        ST_IDLE: if (bus.start) begin
          op_q  <= op_e'(bus.op);
          upd_q <= bus.update_flags;
          last  <= last_c;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: if (xfer && cnt == last) state <= ST_FLUSH;
        ST_FLUSH: begin
          state <= ST_IDLE;
          if (upd_q) begin
            flags[FLAG_S] <= s_pend;
            flags[FLAG_Z] <= z_acc;
            if (is_arith(op_q)) begin
              flags[FLAG_C] <= carry;
              flags[FLAG_V] <= v_pend;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == ST_RUN);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_FLUSH);
  assign bus.out_valid  = out_v;
  assign bus.result_out = res_q;
  assign bus.flag_c     = flags[FLAG_C];
  assign bus.flag_v     = flags[FLAG_V];
  assign bus.flag_s     = flags[FLAG_S];
  assign bus.flag_z     = flags[FLAG_Z];

endmodule

// File: tb/tb_serial_alu_n.sv
// tb_serial_alu_n: directed vectors against a word-level
// arithmetic model with a per-cycle digit scoreboard.
module tb_serial_alu_n;
  import serial_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_alu_n_if #(.DIGIT_BITS(2), .MAX_WORDS(4)) bus ();

  serial_alu_n #(
    .DIGIT_BITS(2),
    .REG_BITS  (8),
    .MAX_WORDS (4)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int dig_cnt  = 0;
  int done_cnt = 0;
  logic [1:0]  exp_q[$];
  logic [63:0] got_word;
  logic [63:0] m_res;
  logic mc = 0, mv = 0, ms = 0, mz = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_digit: got %0h, expected no digit",
                   bus.result_out);
        end else begin
          check("digit", 64'(bus.result_out), 64'(exp_q.pop_front()));
          got_word = got_word | (64'(bus.result_out) << (2 * dig_cnt));
          dig_cnt++;
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic model(input op_e o, input logic [31:0] a,
                       input logic [31:0] b, input int len,
                       input bit upd);
    int w;
    logic [63:0] mask, x, y, full;
    logic cin;
    w    = len * 8;
    mask = (64'd1 << w) - 64'd1;
    x    = 64'(a) & mask;
    y    = 64'(b) & mask;
    cin  = 1'b0;
    case (o)
      OP_SUB, OP_CMP: begin y = ~y & mask; cin = 1'b1; end
      OP_SBC: begin y = ~y & mask; cin = mc; end
      OP_ADC: cin = mc;
      OP_NEG: begin y = ~x & mask; x = 64'd0; cin = 1'b1; end
      default: ;
    endcase
    full = x + y + 64'(cin);
    case (o)
      OP_AND:  m_res = x & y;
      OP_OR:   m_res = x | y;
      OP_XOR:  m_res = x ^ y;
      OP_MOV:  m_res = y;
      default: m_res = full & mask;
    endcase
    if (o != OP_CMP)
      for (int i = 0; i < w / 2; i++) exp_q.push_back(m_res[2*i +: 2]);
    if (upd) begin
      ms = m_res[w-1];
      mz = (m_res == 64'd0);
      if (!(o inside {OP_AND, OP_OR, OP_XOR, OP_MOV})) begin
        mc = full[w];
        mv = (x[w-1] == y[w-1]) && (m_res[w-1] != x[w-1]);
      end
    end
  endtask

  task automatic run_op(input op_e o, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] len_in,
                        input bit upd, input int gap_at, input int gap,
                        input bit poke, input string nm);
    int len, n, c0, d0;
    len = (len_in == 0) ? 1 : (len_in > 4) ? 4 : int'(len_in);
    n   = len * 4;
    got_word = 64'd0;
    dig_cnt  = 0;
    d0       = done_cnt;
    model(o, a, b, len, upd);
    bus.start        = 1'b1;
    bus.op           = o;
    bus.len_words    = len_in;
    bus.update_flags = upd;
    c0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({nm, "_busy"}, 64'(bus.busy), 64'd1);
    for (int k = 0; k < n; k++) begin
      if (k == gap_at && gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.a_in     = a[2*k +: 2];
      bus.b_in     = b[2*k +: 2];
      bus.start    = poke;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.start    = poke;
    @(negedge clk);
    check({nm, "_done"}, 64'(bus.done), 64'd1);
    check({nm, "_latency"}, 64'(cyc - c0), 64'(n + gap + 1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({nm, "_idle"}, 64'(bus.busy), 64'd0);
    check({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({nm, "_digits"}, 64'(dig_cnt), (o == OP_CMP) ? 64'd0 : 64'(n));
    check({nm, "_word"}, got_word, (o == OP_CMP) ? 64'd0 : m_res);
    check({nm, "_flags"},
          64'({bus.flag_z, bus.flag_s, bus.flag_v, bus.flag_c}),
          64'({mz, ms, mv, mc}));
  endtask

  task automatic pin(input string nm, input logic [63:0] res,
                     input logic [3:0] zsvc);
    check({nm, "_pin_res"}, m_res, res);
    check({nm, "_pin_flags"}, 64'({mz, ms, mv, mc}), 64'(zsvc));
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_in_ready"},  64'(bus.in_ready), 64'd0);
    check({nm, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({nm, "_done"},      64'(bus.done), 64'd0);
    check({nm, "_busy"},      64'(bus.busy), 64'd0);
    check({nm, "_result"},    64'(bus.result_out), 64'd0);
    check({nm, "_flags"},
          64'({bus.flag_z, bus.flag_s, bus.flag_v, bus.flag_c}), 64'd0);
  endtask

  initial begin
    int d0;
    logic [31:0] ra, rb;
    bus.start = 0; bus.op = 0; bus.len_words = 0;
    bus.update_flags = 0; bus.in_valid = 0;
    bus.a_in = 0; bus.b_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(OP_ADD, 32'h00FF, 32'h0001, 3'd2, 1, -1, 0, 0, "add");
    pin("add", 64'h0100, 4'b0000);
    run_op(OP_SUB, 32'h80, 32'h01, 3'd1, 1, -1, 0, 0, "sub");
    pin("sub", 64'h7F, 4'b0011);
    run_op(OP_XOR, 32'hA5A5A5A5, 32'hFFFFFFFF, 3'd7, 1, -1, 0, 0, "xor");
    pin("xor", 64'h5A5A5A5A, 4'b0011);
    run_op(OP_ADC, 32'hFFFFFFFF, 32'h0, 3'd4, 1, -1, 0, 0, "adc");
    pin("adc", 64'h0, 4'b1001);
    run_op(OP_SBC, 32'h05, 32'h07, 3'd1, 1, -1, 0, 0, "sbc");
    pin("sbc", 64'hFE, 4'b0100);
    run_op(OP_ADD, 32'h1234, 32'h1111, 3'd2, 0, 3, 3, 1, "gap");
    pin("gap", 64'h2345, 4'b0100);
    run_op(OP_CMP, 32'h12, 32'h12, 3'd1, 1, -1, 0, 0, "cmp");
    pin("cmp", 64'h0, 4'b1001);
    run_op(OP_NEG, 32'h01, 32'h0, 3'd1, 1, -1, 0, 0, "neg");
    pin("neg", 64'hFF, 4'b0100);
    run_op(OP_AND, 32'hF0, 32'h3C, 3'd0, 1, -1, 0, 0, "and");
    pin("and", 64'h30, 4'b0000);
    run_op(OP_MOV, 32'h11, 32'hC3, 3'd1, 0, -1, 0, 0, "mov");

    d0 = done_cnt;
    ra = 32'h89ABCDEF;
    rb = 32'h01234567;
    model(OP_ADD, ra, rb, 4, 0);
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.len_words = 3'd4;
    bus.update_flags = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.a_in = ra[2*k +: 2];
      bus.b_in = rb[2*k +: 2];
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk_zero("abort");
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    mc = 0; mv = 0; ms = 0; mz = 0;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    run_op(OP_ADD, 32'h7F, 32'h01, 3'd1, 1, -1, 0, 0, "post");
    pin("post", 64'h80, 4'b0110);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
